display_arbiter: RTL and testbench

- Shares the single 4-digit seven-segment scanner between up to NUM_REQ producers, e.g. score, high score, move count and debug.
- Grants the display round-robin. Each grant lasts at least HOLD_CYCLES so the viewer can read it.
- Drives the registered hex/dots value that the seven-segment scan driver multiplexes onto the anodes.

---
 rtl/display_pkg.sv | 14 +
 rtl/rr_pick.sv | 32 +++
 rtl/display_arbiter.sv | 170 +++++++++++++++++
 tb/tb_display_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display sharing logic.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    EXTEND
  } disp_arb_state_t;

  // Value shown on the display after reset, before any requester has won.
  localparam logic [15:0] BLANK_HEX  = 16'h0000;
  localparam logic [3:0]  BLANK_DOTS = 4'h0;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request bit,
// searching upward from 'start' and wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic          vld
);

  // Walk the N positions in rotated order; the first hit wins.
  always_comb begin
    int              sum;
    logic [IW-1:0]   idx;
    gnt = '0;
    vld = 1'b0;
    sum = 0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      sum = int'(start) + i;
      if (sum >= N) sum = sum - N;
      idx = IW'(sum);
      if (!vld && req[idx]) begin
        gnt[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner selection for the shared 4-digit seven-segment display.
// Each grant lasts at least HOLD_CYCLES; a sole requester keeps the display
// (EXTEND) until someone else asks or it lets go.
// Optional: define DISPLAY_ARB_URGENT_EN to let requester 0 preempt any owner
// and hold the display non-preemptibly until its timer expires.
module display_arbiter
  import display_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int CNT_W       = $clog2(HOLD_CYCLES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [16*NUM_REQ-1:0] req_hex,
  input  logic [4*NUM_REQ-1:0]  req_dots,
  output logic [15:0]           hex_out,
  output logic [3:0]            dots_out,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  busy
);

  localparam int OW = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  disp_arb_state_t      state_q, state_d;
  logic [CNT_W-1:0]     timer_q, timer_d;
  logic [OW-1:0]        owner_q, owner_d;   // doubles as last_owner while IDLE
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [15:0]          hex_q, hex_d;
  logic [3:0]           dots_q, dots_d;

  logic [15:0]          hex_slice  [NUM_REQ];
  logic [3:0]           dots_slice [NUM_REQ];
  logic [OW-1:0]        start;
  logic [NUM_REQ-1:0]   pick_gnt;
  logic                 pick_vld;
  logic [OW-1:0]        pick_idx;
  logic                 owner_req;
  logic                 expired;
  logic                 lock;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign hex_slice[i]  = req_hex[16*i +: 16];
    assign dots_slice[i] = req_dots[4*i +: 4];
  end

  assign start     = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + OW'(1);
  assign owner_req = req[owner_q];
  assign expired   = (timer_q == '0);

  // The current owner never competes against itself: only others are searched.
  rr_pick #(
    .N  (NUM_REQ),
    .IW (OW)
  ) u_pick (
    .req   (req & ~grant_q),
    .start (start),
    .gnt   (pick_gnt),
    .vld   (pick_vld)
  );

  // Convert the one-hot winner to an index for the owner register.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) pick_idx = OW'(i);
    end
  end

`ifdef DISPLAY_ARB_URGENT_EN
  assign lock = (owner_q == '0) && !expired;
`else
  assign lock = 1'b0;
`endif

  // Next-state, timer, grant and display-value selection.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    owner_d = owner_q;
    grant_d = grant_q;
    hex_d   = hex_q;
    dots_d  = dots_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_gnt;
          owner_d = pick_idx;
          timer_d = RELOAD;
          state_d = HOLD;
        end
      end
      HOLD, EXTEND: begin
        // A dropped owner freezes the display at its last captured value.
        if (owner_req) begin
          hex_d  = hex_slice[owner_q];
          dots_d = dots_slice[owner_q];
        end
        timer_d = expired ? '0 : timer_q - CNT_W'(1);
        if (state_q == HOLD) begin
          if (expired) begin
            if (pick_vld) begin
              grant_d = pick_gnt;
              owner_d = pick_idx;
              timer_d = RELOAD;
            end else if (owner_req) begin
              timer_d = RELOAD;
              state_d = EXTEND;
            end else begin
              grant_d = '0;
              state_d = IDLE;
            end
          end
        end else begin
          if (pick_vld && (!lock || !owner_req)) begin
            grant_d = pick_gnt;
            owner_d = pick_idx;
            timer_d = RELOAD;
            state_d = HOLD;
          end else if (!owner_req) begin
            grant_d = '0;
            timer_d = '0;
            state_d = IDLE;
          end else if (expired) begin
            timer_d = RELOAD;
          end
        end
`ifdef DISPLAY_ARB_URGENT_EN
        if (req[0] && (owner_q != '0)) begin
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1};
          owner_d = '0;
          timer_d = RELOAD;
          state_d = HOLD;
        end
`endif
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset blanks the display immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      owner_q <= OW'(NUM_REQ - 1);
      grant_q <= '0;
      hex_q   <= BLANK_HEX;
      dots_q  <= BLANK_DOTS;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      hex_q   <= hex_d;
      dots_q  <= dots_d;
    end
  end

  assign hex_out  = hex_q;
  assign dots_out = dots_q;
  assign grant    = grant_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter (NUM_REQ=4, HOLD_CYCLES=4).
// Every change of {grant, hex_out, dots_out, busy} must match the next
// queued expectation, including the cycle on which it appears.
module tb_display_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [63:0] req_hex;
  logic [15:0] req_dots;
  logic [15:0] hex_out;
  logic [3:0]  dots_out;
  logic [3:0]  grant;
  logic        busy;

  always #5 clk = ~clk;

  display_arbiter #(
    .NUM_REQ     (4),
    .HOLD_CYCLES (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_hex  (req_hex),
    .req_dots (req_dots),
    .hex_out  (hex_out),
    .dots_out (dots_out),
    .grant    (grant),
    .busy     (busy)
  );

  typedef struct packed {
    int          cyc;
    logic [3:0]  g;
    logic [15:0] h;
    logic [3:0]  d;
    logic        b;
  } ev_t;

  ev_t q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  int  base     = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic at(input int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ev(input int dc, input logic [3:0] g, input logic [15:0] h,
                    input logic [3:0] d, input logic b);
    ev_t e;
    e.cyc = base + dc;
    e.g = g; e.h = h; e.d = d; e.b = b;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: pop and compare on every visible output change.
  initial begin
    ev_t         e;
    logic [24:0] cur;
    logic [24:0] prev;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev = '0;
      end else begin
        cur = {grant, hex_out, dots_out, busy};
        if (cur !== prev) begin
          checks++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL out_event unexpected cyc=%0d got grant=%b hex=%h dots=%h busy=%b",
                     cyc, grant, hex_out, dots_out, busy);
          end else begin
            e = q.pop_front();
            if (e.cyc != cyc || {e.g, e.h, e.d, e.b} !== cur) begin
              failures++;
              $display("FAIL out_event cyc=%0d grant=%b hex=%h dots=%h busy=%b want cyc=%0d grant=%b hex=%h dots=%h busy=%b",
                       cyc, grant, hex_out, dots_out, busy, e.cyc, e.g, e.h, e.d, e.b);
            end
          end
          prev = cur;
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    req_hex  = {16'h3333, 16'h2048, 16'h1111, 16'h0128};
    req_dots = {4'h8, 4'h4, 4'h3, 4'h1};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_hex",   32'(hex_out), 32'h0);
    chk("rst_dots",  32'(dots_out), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Single requester, then 0 and 2 alternating, then everyone idle.
    base = cyc;
    ev(1,  4'b0001, 16'h0000, 4'h0, 1'b1);
    ev(2,  4'b0001, 16'h0128, 4'h1, 1'b1);
    ev(5,  4'b0100, 16'h0128, 4'h1, 1'b1);
    ev(6,  4'b0100, 16'h2048, 4'h4, 1'b1);
    ev(9,  4'b0001, 16'h2048, 4'h4, 1'b1);
    ev(10, 4'b0001, 16'h0128, 4'h1, 1'b1);
    ev(13, 4'b0100, 16'h0128, 4'h1, 1'b1);
    ev(14, 4'b0100, 16'h2048, 4'h4, 1'b1);
    ev(17, 4'b0000, 16'h2048, 4'h4, 1'b0);
    req = 4'b0001;
    at(2);  req = 4'b0101;
    at(14); req = 4'b0000;
    at(18);

    // Owner 0 drops after one HOLD cycle: display freezes, grant kept to expiry.
    base = cyc;
    ev(1, 4'b0001, 16'h2048, 4'h4, 1'b1);
    ev(2, 4'b0001, 16'h0128, 4'h1, 1'b1);
    ev(5, 4'b0000, 16'h0128, 4'h1, 1'b0);
    req = 4'b0001;
    at(2); req = 4'b0000; req_hex[15:0] = 16'h9999;
    at(6);

    // Drop and re-assert within HOLD: no timer restart, then EXTEND release.
    base = cyc;
    ev(1, 4'b0001, 16'h0128, 4'h1, 1'b1);
    ev(2, 4'b0001, 16'h0555, 4'h2, 1'b1);
    ev(4, 4'b0001, 16'h0777, 4'h2, 1'b1);
    ev(6, 4'b0000, 16'h0777, 4'h2, 1'b0);
    req_hex[15:0] = 16'h0555; req_dots[3:0] = 4'h2; req = 4'b0001;
    at(2); req = 4'b0000;
    at(3); req = 4'b0001; req_hex[15:0] = 16'h0777;
    at(5); req = 4'b0000;
    at(7);
    req_hex[15:0] = 16'h0128; req_dots[3:0] = 4'h1;

    // Requester 3 alone (EXTEND), req[1] takes over, then wrap order 1->3->0->1.
    base = cyc;
    ev(1,  4'b1000, 16'h0777, 4'h2, 1'b1);
    ev(2,  4'b1000, 16'h3333, 4'h8, 1'b1);
    ev(7,  4'b0010, 16'h3333, 4'h8, 1'b1);
    ev(8,  4'b0010, 16'h1111, 4'h3, 1'b1);
    ev(11, 4'b1000, 16'h1111, 4'h3, 1'b1);
    ev(12, 4'b1000, 16'h3333, 4'h8, 1'b1);
    ev(15, 4'b0001, 16'h3333, 4'h8, 1'b1);
    ev(16, 4'b0001, 16'h0128, 4'h1, 1'b1);
    ev(19, 4'b0010, 16'h0128, 4'h1, 1'b1);
    ev(20, 4'b0010, 16'h1111, 4'h3, 1'b1);
    req = 4'b1000;
    at(6); req = 4'b1010;
    at(8); req = 4'b1011;
    at(21);

    // Asynchronous reset in the middle of a HOLD.
    #2 reset = 1'b0;
    #1;
    chk("async_rst_grant", 32'(grant), 32'h0);
    chk("async_rst_hex",   32'(hex_out), 32'h0);
    chk("async_rst_dots",  32'(dots_out), 32'h0);
    chk("async_rst_busy",  32'(busy), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // After release the search restarts from index 0.
    base = cyc;
    ev(1, 4'b0001, 16'h0000, 4'h0, 1'b1);
    ev(2, 4'b0001, 16'h0128, 4'h1, 1'b1);
    ev(5, 4'b0000, 16'h0128, 4'h1, 1'b0);
    reset = 1'b1;
    at(2); req = 4'b0000;
    at(6);

`ifdef DISPLAY_ARB_URGENT_EN
    // Urgent requester 0 preempts owner 2; owner 2 waits out the urgent hold.
    base = cyc;
    ev(1,  4'b0100, 16'h0128, 4'h1, 1'b1);
    ev(2,  4'b0100, 16'h2048, 4'h4, 1'b1);
    ev(3,  4'b0001, 16'h2048, 4'h4, 1'b1);
    ev(4,  4'b0001, 16'h0128, 4'h1, 1'b1);
    ev(7,  4'b0100, 16'h0128, 4'h1, 1'b1);
    ev(8,  4'b0100, 16'h2048, 4'h4, 1'b1);
    ev(11, 4'b0000, 16'h2048, 4'h4, 1'b0);
    req = 4'b0100;
    at(2); req = 4'b0101;
    at(7); req = 4'b0100;
    at(8); req = 4'b0000;
    at(12);
`endif

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL pending_events got=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
